// File: rtl/alu_op_sequencer.sv
// Issue stage for the 8-bit combinational ALU: buffers commands in a FIFO, drives registered
// operands, waits SETTLE cycles, then returns results in order. Optional tags: ALU_SEQ_TAG_EN.
module alu_op_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef ALU_SEQ_TAG_EN
  input  logic [3:0]               cmd_tag,
  output logic [3:0]               rsp_tag,
`endif
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  input  logic [3:0]               cmd_s,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic [3:0]               alu_s,
  input  logic [7:0]               alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [AW:0]   FullCount  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] SettleLoad = CW'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [CW-1:0]   r_settle;
  logic [7:0]      r_mem_a [DEPTH];
  logic [7:0]      r_mem_b [DEPTH];
  logic [3:0]      r_mem_s [DEPTH];
  logic [7:0]      r_alu_a;
  logic [7:0]      r_alu_b;
  logic [3:0]      r_alu_s;
  logic [7:0]      r_rsp_data;
  logic            w_push;
  logic            w_pop;
  logic            w_capture;

  assign cmd_ready = (r_count < FullCount);
  assign w_push    = cmd_valid & cmd_ready;

  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      StIdle: begin
        if (r_count != '0) begin
          w_pop     = 1'b1;
          w_state_d = StSettle;
        end
      end
      StSettle: begin
        if (r_settle == '0) begin
          w_capture = 1'b1;
          w_state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          // Back-to-back issue: next command enters the ALU on the handshake edge.
          if (r_count != '0) begin
            w_pop     = 1'b1;
            w_state_d = StSettle;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= cmd_a;
      r_mem_b[r_wr_ptr] <= cmd_b;
      r_mem_s[r_wr_ptr] <= cmd_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle   <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_s    <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_pop) begin
        r_alu_a  <= r_mem_a[r_rd_ptr];
        r_alu_b  <= r_mem_b[r_rd_ptr];
        r_alu_s  <= r_mem_s[r_rd_ptr];
        r_settle <= SettleLoad;
      end else if (r_state == StSettle && r_settle != '0) begin
        r_settle <= r_settle - CW'(1);
      end
      if (w_capture) r_rsp_data <= alu_result;
    end
  end

`ifdef ALU_SEQ_TAG_EN
  logic [3:0] r_mem_tag [DEPTH];
  logic [3:0] r_issue_tag;
  logic [3:0] r_rsp_tag;

  always_ff @(posedge clk) begin
    if (w_push) r_mem_tag[r_wr_ptr] <= cmd_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_tag <= '0;
      r_rsp_tag   <= '0;
    end else begin
      if (w_pop)     r_issue_tag <= r_mem_tag[r_rd_ptr];
      if (w_capture) r_rsp_tag   <= r_issue_tag;
    end
  end

  assign rsp_tag = r_rsp_tag;
`endif

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_s     = r_alu_s;
  assign rsp_data  = r_rsp_data;
  assign rsp_valid = (r_state == StResp);
  assign busy      = (r_state != StIdle) || (r_count != '0);
  assign count     = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an adder standing in for the ALU.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_s;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_s;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;
  logic [2:0] count;
`ifdef ALU_SEQ_TAG_EN
  logic [3:0] cmd_tag;
  logic [3:0] rsp_tag;
`endif

  int n_checks;
  int n_errors;

  assign alu_result = alu_a + alu_b;

  alu_op_sequencer #(
    .DEPTH  (4),
    .SETTLE (2)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef ALU_SEQ_TAG_EN
    .cmd_tag    (cmd_tag),
    .rsp_tag    (rsp_tag),
`endif
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_s      (cmd_s),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next active edge; all sampling and driving happens here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_s     = s;
  endtask

  logic [7:0] fa   [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] fb   [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
  logic [7:0] fsum [6] = '{8'h12, 8'h24, 8'h36, 8'h48, 8'h5A, 8'h6C};
  logic [7:0] ta   [3] = '{8'h01, 8'h10, 8'hFF};
  logic [7:0] tb   [3] = '{8'h02, 8'h20, 8'h02};
  logic [7:0] tsum [3] = '{8'h03, 8'h30, 8'h01};

  initial begin
    int k;
    int cyc;
    int last;
    logic acc;

    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_s     = '0;
    rsp_ready = 1'b0;
`ifdef ALU_SEQ_TAG_EN
    cmd_tag   = '0;
`endif

    // Reset state
    repeat (3) tick();
    check_eq("rst_alu_a", alu_a, 0);
    check_eq("rst_alu_b", alu_b, 0);
    check_eq("rst_alu_s", alu_s, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("idle_rsp_valid", rsp_valid, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_alu_a", alu_a, 0);

    // Single op
    rsp_ready = 1'b1;
    set_cmd(8'h7E, 8'h5F, 4'h0);
    tick();                                   // E0
    cmd_valid = 1'b0;
    check_eq("single_count_e0", count, 1);
    tick();                                   // E1
    check_eq("single_alu_a", alu_a, 8'h7E);
    check_eq("single_alu_b", alu_b, 8'h5F);
    check_eq("single_valid_e1", rsp_valid, 0);
    tick();                                   // E2
    check_eq("single_valid_e2", rsp_valid, 0);
    tick();                                   // E3
    check_eq("single_valid_e3", rsp_valid, 1);
    check_eq("single_data", rsp_data, 8'hDD);
    tick();                                   // E4
    check_eq("single_valid_e4", rsp_valid, 0);
    check_eq("single_busy_e4", busy, 0);

    // Fill and backpressure
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_cmd(fa[i], fb[i], 4'(i));
`ifdef ALU_SEQ_TAG_EN
      cmd_tag = 4'(i + 1);
`endif
      check_eq("fill_ready", cmd_ready, 1);
      tick();
    end
    set_cmd(fa[5], fb[5], 4'd5);
`ifdef ALU_SEQ_TAG_EN
    cmd_tag = 4'd6;
`endif
    check_eq("fill_count", count, 4);
    check_eq("fill_ready_low", cmd_ready, 0);
    check_eq("fill_valid", rsp_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("stall_data", rsp_data, fsum[0]);
      check_eq("stall_alu_a", alu_a, fa[0]);
      check_eq("stall_alu_b", alu_b, fb[0]);
      check_eq("stall_count", count, 4);
    end
    rsp_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 100 && k < 6; c++) begin
      if (rsp_valid) begin
        check_eq("drain_data", rsp_data, fsum[k]);
`ifdef ALU_SEQ_TAG_EN
        check_eq("drain_tag", rsp_tag, 32'(k + 1));
`endif
        k++;
      end
      acc = cmd_valid & cmd_ready;
      tick();
      if (acc) cmd_valid = 1'b0;
    end
    check_eq("drain_nrsp", k, 6);
    check_eq("drain_cmd_valid", cmd_valid, 0);
    tick();
    check_eq("drain_count", count, 0);
    check_eq("drain_busy", busy, 0);

    // Throughput with rsp_ready high
    rsp_ready = 1'b1;
    k = 0;
    cyc = 0;
    last = 0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(ta[i], tb[i], 4'(i + 8));
      tick();
      cyc++;
    end
    cmd_valid = 1'b0;
    while (k < 3 && cyc < 60) begin
      if (rsp_valid) begin
        check_eq("tput_data", rsp_data, tsum[k]);
        if (k == 0) check_eq("tput_first", cyc, 4);
        else        check_eq("tput_gap", cyc - last, 3);
        last = cyc;
        k++;
      end
      tick();
      cyc++;
    end
    check_eq("tput_nrsp", k, 3);

    // Reset mid-operation
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(8'h40 + 8'(i), 8'h01, 4'h3);
      tick();
    end
    cmd_valid = 1'b0;
    check_eq("mid_count", count, 2);
    check_eq("mid_busy", busy, 1);
    check_eq("mid_alu_a", alu_a, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_alu_a", alu_a, 0);
    check_eq("mid_rst_alu_s", alu_s, 0);
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", cmd_ready, 1);
    #2;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) k++;
    end
    check_eq("post_rst_rsp", k, 0);
    check_eq("post_rst_count", count, 0);

`ifdef ALU_SEQ_TAG_EN
    // Tag carry
    rsp_ready = 1'b0;
    set_cmd(8'h01, 8'h01, 4'h0);
    cmd_tag = 4'hA;
    tick();
    set_cmd(8'h02, 8'h02, 4'h0);
    cmd_tag = 4'h5;
    tick();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 2; c++) begin
      if (rsp_valid) begin
        check_eq("tag_data", rsp_data, (k == 0) ? 8'h02 : 8'h04);
        check_eq("tag_val", rsp_tag, (k == 0) ? 4'hA : 4'h5);
        k++;
      end
      tick();
    end
    check_eq("tag_nrsp", k, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream issue stage for the 8-bit ALU (operands a, b and 4-bit select s in; 8-bit alu_result out). Accepts operation commands through a valid/ready port and buffers them in a small FIFO. Drives registered operands/opcode into the combinational ALU, waits a fixed settle time, then captures alu_result and returns it through a valid/ready response port, in order.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >=2
SETTLE, 2, cycles from ALU operand update to result capture; >=1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept a command
cmd_a  input  8  operand a
cmd_b  input  8  operand b
cmd_s  input  4  ALU select
alu_a  output  8  registered operand to ALU a
alu_b  output  8  registered operand to ALU b
alu_s  output  4  registered select to ALU s
alu_result  input  8  ALU combinational result
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_data  output  8  captured result
busy  output  1  state!=IDLE or FIFO non-empty
count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO pointers/count 0, alu_a/alu_b/alu_s/rsp_data 0, rsp_valid 0, busy 0. Reset mid-operation discards in-flight and queued commands; no response is produced for them.
- Push on cmd_valid&cmd_ready. cmd_ready = (count<DEPTH), registered-count based; a pop in the same cycle does not raise ready when full. Simultaneous push+pop leaves count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETTLE, RESP.
- IDLE: if count!=0, pop head into alu_a/b/s at this edge, load settle counter, go SETTLE. Otherwise alu_* hold their last value.
- SETTLE: count down SETTLE cycles; at the edge ending the SETTLE-th cycle after the alu_* update, capture alu_result into rsp_data, set rsp_valid, go RESP.
- RESP: rsp_valid and rsp_data held stable until rsp_ready. On handshake edge: rsp_valid clears; if count!=0, pop the next command into alu_* at the same edge and go SETTLE (back-to-back); else go IDLE.
- Latency: command accepted at edge E0 into an empty, idle block -> alu_* update at E1 -> rsp_valid high from E(1+SETTLE).
- Throughput with rsp_ready held high: one result per SETTLE+1 cycles.
- alu_* never change while in SETTLE or RESP.
- Ordering: responses strictly in command order; no drops or duplicates.

Optional Feature:
ALU_SEQ_TAG_EN: when defined, adds input cmd_tag[3:0] and output rsp_tag[3:0]. The tag is stored per FIFO entry and carried with the command. It is presented on rsp_tag with rsp_data, and reset value is 0. When not defined, these ports and the tag storage are absent; all other behaviour is identical.

Test Plan:
Bench stubs the ALU as alu_result = alu_a+alu_b (mod 256). SETTLE=2, DEPTH=4.
- Reset: hold rst_n=0 -> all outputs 0, cmd_ready=1, count=0; release -> no activity with cmd_valid=0.
- Single op: push a=0x7E b=0x5F s=0x0 at E0, rsp_ready=1 -> alu_a=0x7E, alu_b=0x5F at E1; rsp_valid=1, rsp_data=0xDD from E3; rsp_valid=0 after E4.
- Fill/backpressure: rsp_ready=0, cmd_valid held with 6 distinct commands -> 5 accepted (1 in ALU + 4 queued), count=4, cmd_ready=0. The 6th stalls. rsp_data and alu_* are stable for 10 cycles. Then rsp_ready=1 -> 6 results in order, count returns to 0.
- Throughput: rsp_ready=1, 3 commands queued (0x01+0x02, 0x10+0x20, 0xFF+0x02) -> rsp_valid pulses every 3 cycles with 0x03, 0x30, 0x01 (wrap).
- Reset mid-op: in SETTLE with 2 queued, pulse rst_n low asynchronously (between edges) -> outputs 0 immediately. After release, no rsp_valid for 20 cycles, count=0.
- Tag (ALU_SEQ_TAG_EN): push tags 0xA, 0x5 -> rsp_tag returns 0xA then 0x5, aligned with rsp_data.
